fc_seq_ctrl: RTL and testbench

FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

---
 rtl/fc_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fc_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fc_seq_ctrl
// Sequencer for one fully connected layer. N_OUT output neurons share a
// single neuron datapath. The block launches that datapath once per output
// slot, collects each result in a shadow buffer, and publishes all results
// on `out` together at the end of the run. A per-neuron watchdog aborts the
// run if the neuron does not answer within TMO WAIT cycles.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   start_flag  one-cycle request for a layer evaluation; honoured only in IDLE
//   in          layer input vector, captured when a start is accepted
//   neu_in      registered copy of `in`, held for the whole run
//   neu_sel     index of the scheduled neuron (weight/bias select)
//   neu_start   one-cycle launch pulse to the shared neuron
//   neu_end     neuron done pulse; neu_out is valid in the same cycle
//   neu_out     result of the neuron at neu_sel
//   out         packed results, slot 0 in the most significant field
//   end_flag    one-cycle pulse when a run finishes (normally or on abort)
//   busy        high whenever the sequencer is not idle
//   err         sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module fc_seq_ctrl #(
  parameter int N_OUT = 16,
  parameter int OUT_W = 9,
  parameter int TMO   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_flag,
  input  logic [127:0]              in,
  output logic [127:0]              neu_in,
  output logic [$clog2(N_OUT)-1:0]  neu_sel,
  output logic                      neu_start,
  input  logic                      neu_end,
  input  logic [OUT_W-1:0]          neu_out,
  output logic [N_OUT*OUT_W-1:0]    out,
  output logic                      end_flag,
  output logic                      busy,
  output logic                      err
);

  localparam int SEL_W = $clog2(N_OUT);
  localparam int WD_W  = $clog2(TMO + 1);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_OUT - 1);
  // The watchdog counts from 0 in the first WAIT cycle, so the TMO-th
  // consecutive WAIT cycle without neu_end sees a count of TMO-1.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [WD_W-1:0]          wdog;
  logic [OUT_W-1:0]         shadow [N_OUT];
  logic [N_OUT*OUT_W-1:0]   out_fill;

  logic sel_last;
  logic wd_expire;

  assign sel_last  = (neu_sel == SEL_LAST);
  assign wd_expire = (wdog == WD_LAST);

  // Control outputs are pure state decodes, so they carry no extra latency
  // and drop to zero together with the state register on reset.
  assign neu_start = (state == LAUNCH);
  assign end_flag  = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_flag) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (neu_end) begin
          state_nxt = sel_last ? DONE : LAUNCH;
        end else if (wd_expire) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Full result image as it will look after the current edge: the slot
  // being written right now is taken from neu_out, all others from the
  // shadow buffer. Used only when the last slot completes.
  always_comb begin
    out_fill = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_fill[(N_OUT-1-i)*OUT_W +: OUT_W] =
        (SEL_W'(i) == neu_sel) ? neu_out : shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      neu_in  <= '0;
      neu_sel <= '0;
      out     <= '0;
      err     <= 1'b0;
      wdog    <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start_flag) begin
            neu_in  <= in;
            neu_sel <= '0;
            err     <= 1'b0;
          end
        end
        LAUNCH: begin
          wdog <= '0;
        end
        WAIT: begin
          if (neu_end) begin
            shadow[neu_sel] <= neu_out;
            if (sel_last) begin
              out <= out_fill;
            end else begin
              neu_sel <= neu_sel + SEL_W'(1);
            end
          end else if (wd_expire) begin
            // Abort: out keeps the previous run's results.
            err <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
module tb_fc_seq_ctrl;

  localparam int N_OUT = 16;
  localparam int OUT_W = 9;
  localparam int TMO   = 255;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start_flag = 1'b0;
  logic [127:0]           in = '0;
  logic [127:0]           neu_in;
  logic [3:0]             neu_sel;
  logic                   neu_start;
  logic                   neu_end_w;
  logic [OUT_W-1:0]       neu_out_w;
  logic [N_OUT*OUT_W-1:0] out;
  logic                   end_flag;
  logic                   busy;
  logic                   err;

  // neuron model and spurious-pulse injection
  logic             model_end = 1'b0;
  logic [OUT_W-1:0] model_out = '0;
  logic             spur_end = 1'b0;
  logic [OUT_W-1:0] spur_out = 9'h1FF;
  int               model_ofs = 0;
  int               hold_slot = -1;

  assign neu_end_w = model_end | spur_end;
  assign neu_out_w = spur_end ? spur_out : model_out;

  fc_seq_ctrl #(.N_OUT(N_OUT), .OUT_W(OUT_W), .TMO(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_flag (start_flag),
    .in         (in),
    .neu_in     (neu_in),
    .neu_sel    (neu_sel),
    .neu_start  (neu_start),
    .neu_end    (neu_end_w),
    .neu_out    (neu_out_w),
    .out        (out),
    .end_flag   (end_flag),
    .busy       (busy),
    .err        (err)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // monitor: cycle counter plus log of neu_start and end_flag pulses
  int cyc = 0;
  int n_st = 0;
  int n_ef = 0;
  int st_cyc [0:63];
  int st_sel [0:63];
  int ef_cyc [0:7];

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (neu_start && n_st < 64) begin
      st_cyc[n_st] = cyc;
      st_sel[n_st] = int'(neu_sel);
      n_st++;
    end
    if (end_flag && n_ef < 8) begin
      ef_cyc[n_ef] = cyc;
      n_ef++;
    end
  end

  // neuron with L=3: neu_end three cycles after neu_start, result sel+1+ofs
  initial begin : neuron
    int cnt;
    int sel;
    cnt = 0;
    sel = 0;
    forever begin
      @(negedge clk);
      model_end = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && sel != hold_slot) begin
          model_end = 1'b1;
          model_out = OUT_W'(sel + 1 + model_ofs);
        end
      end
      if (neu_start) begin
        sel = int'(neu_sel);
        cnt = 3;
      end
    end
  end

  function automatic logic [N_OUT*OUT_W-1:0] exp_out(input int ofs);
    logic [N_OUT*OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_OUT; i++) begin
      r[(N_OUT-1-i)*OUT_W +: OUT_W] = OUT_W'(i + 1 + ofs);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_st = 0;
    n_ef = 0;
  endtask

  // One layer run. rel counts cycles from the cycle in which start_flag is
  // first driven high; r1/r2 are extra start pulses, spur a spurious neu_end.
  task automatic run(input string tag, input logic [127:0] pat, input int ofs,
                     input int hold, input int r1, input int r2, input int spur,
                     input int ncyc, input int exp_nst, input int exp_ef_rel,
                     input logic exp_err, input logic [143:0] exp_o);
    int x;
    int bad;
    logic moved;
    logic done_seen;
    logic [143:0] prev;
    @(negedge clk);
    clear_mon();
    x = cyc;
    model_ofs = ofs;
    hold_slot = hold;
    prev = out;
    moved = 1'b0;
    done_seen = 1'b0;
    for (int rel = 0; rel < ncyc; rel++) begin
      start_flag = (rel == 0) || (rel == r1) || (rel == r2);
      in = (rel == 0) ? pat : ~pat;
      spur_end = (rel == spur);
      if (!done_seen) begin
        if (end_flag) done_seen = 1'b1;
        else if (out !== prev) moved = 1'b1;
      end
      @(negedge clk);
    end
    start_flag = 1'b0;
    spur_end = 1'b0;
    bad = 0;
    for (int i = 0; i < n_st; i++) begin
      if (st_sel[i] != i || st_cyc[i] != x + 1 + 4 * i) bad++;
    end
    chk({tag, "_nstart"}, n_st, exp_nst);
    chk({tag, "_sel_seq"}, bad, 0);
    chk({tag, "_nend"}, n_ef, 1);
    chk({tag, "_end_cyc"}, (n_ef > 0) ? ef_cyc[0] - x : -1, exp_ef_rel);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_out"}, out, exp_o);
    chk({tag, "_neu_in"}, neu_in, pat);
    chk({tag, "_out_stable"}, moved, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin : main
    int x;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_end_flag", end_flag, 1'b0);
    chk("rst_neu_start", neu_start, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_out", out, '0);
    chk("rst_neu_in", neu_in, '0);
    chk("rst_neu_sel", neu_sel, '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // spurious neu_end while idle
    spur_end = 1'b1;
    @(negedge clk);
    spur_end = 1'b0;
    @(negedge clk);
    chk("idle_spur_busy", busy, 1'b0);
    chk("idle_spur_out", out, '0);

    // normal run, spurious neu_end in the LAUNCH cycle of slot 1
    run("run1", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, -1, -1, -1, 5,
        70, 16, 65, 1'b0, exp_out(0));

    // start re-pulsed mid-run and in the DONE cycle
    run("run2", 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444, 3, -1, 10, 65, -1,
        70, 16, 65, 1'b0, exp_out(3));

    // slot 5 never answers: watchdog abort, out keeps run2 results
    run("tmo", 128'hDEAD_BEEF_CAFE_F00D_0000_FFFF_1234_5678, 7, 5, -1, -1, -1,
        282, 6, 277, 1'b1, exp_out(3));
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", err, 1'b1);

    // next start clears err
    run("run4", 128'h8000_0000_0000_0000_0000_0000_0000_0001, 9, -1, -1, -1, -1,
        70, 16, 65, 1'b0, exp_out(9));

    // reset during WAIT of slot 7
    @(negedge clk);
    clear_mon();
    x = cyc;
    model_ofs = 20;
    hold_slot = -1;
    start_flag = 1'b1;
    in = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    @(negedge clk);
    start_flag = 1'b0;
    repeat (29) @(negedge clk);
    chk("mrst_in_wait_sel", neu_sel, 4'd7);
    chk("mrst_in_wait_busy", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_out", out, '0);
    chk("mrst_end_flag", end_flag, 1'b0);
    chk("mrst_neu_sel", neu_sel, '0);
    chk("mrst_neu_in", neu_in, '0);
    repeat (6) @(negedge clk);
    chk("mrst_nstart", n_st, 8);
    chk("mrst_no_end", n_ef, 0);
    chk("mrst_dur", cyc - x, 37);

    run("run5", 128'hFFFF_0000_FFFF_0000_AAAA_5555_AAAA_5555, 11, -1, -1, -1, -1,
        70, 16, 65, 1'b0, exp_out(11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
